// File: rtl/small_alu_pkg.sv
// Shared opcodes and the width-generic op/flag evaluation used by the ALU core.
// Operands are passed zero-extended to MAXW bits; w selects the live width (< MAXW).
package small_alu_pkg;

    localparam int OPW  = 3;
    localparam int MAXW = 64;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_SUB  = 3'd1;
    localparam logic [OPW-1:0] OP_XOR  = 3'd2;
    localparam logic [OPW-1:0] OP_AND  = 3'd3;
    localparam logic [OPW-1:0] OP_OR   = 3'd4;
    localparam logic [OPW-1:0] OP_PASS = 3'd5;
    localparam logic [OPW-1:0] OP_ACC  = 3'd6;
    localparam logic [OPW-1:0] OP_ACLR = 3'd7;

    function automatic logic sign_at(input logic [MAXW-1:0] x, input int w);
        return 1'(x >> (w - 1));
    endfunction

    // Returns {c, v, result}; result bits above w are always zero.
    function automatic logic [MAXW+1:0] alu_eval(input logic [OPW-1:0]  op,
                                                 input logic [MAXW-1:0] a,
                                                 input logic [MAXW-1:0] b,
                                                 input logic [MAXW-1:0] acc,
                                                 input int              w);
        logic [MAXW:0]   wide;
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] lhs;
        logic [MAXW-1:0] rhs;
        logic [MAXW-1:0] res;
        logic            c;
        logic            v;
        mask = {MAXW{1'b1}} >> (MAXW - w);
        lhs  = (op == OP_ACC) ? acc : a;
        rhs  = (op == OP_ACC) ? a : b;
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD, OP_ACC: begin
                wide = {1'b0, lhs} + {1'b0, rhs};
                res  = wide[MAXW-1:0] & mask;
                c    = 1'(wide >> w);
                v    = (sign_at(lhs, w) == sign_at(rhs, w)) && (sign_at(res, w) != sign_at(lhs, w));
            end
            OP_SUB: begin
                res = (a - b) & mask;
                c   = (a < b);
                v   = (sign_at(a, w) != sign_at(b, w)) && (sign_at(res, w) != sign_at(a, w));
            end
            OP_XOR:  res = a ^ b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_PASS: res = b;
            default: res = '0;
        endcase
        return {c, v, res};
    endfunction

endpackage

// File: rtl/small_alu_pipe_if.sv
// Operand/result streaming bus for small_alu_pipe: valid/ready on both sides.
interface small_alu_pipe_if #(
    parameter int WIDTH = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [small_alu_pkg::OPW-1:0] op;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             result;
    logic                         flag_c;
    logic                         flag_z;
    logic                         flag_v;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_v
    );
endinterface

// File: rtl/small_alu_core.sv
// Combinational op/flag evaluation for the S2 stage, including next accumulator value.
module small_alu_core
    import small_alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc_next,
    output logic             c,
    output logic             z,
    output logic             v
);
    // Upper bits are always zero for a WIDTH-bit evaluation.
    logic [MAXW-WIDTH-1:0] res_unused;

    assign {c, v, res_unused, result} =
        alu_eval(op, MAXW'(a), MAXW'(b), MAXW'(acc), WIDTH);

    assign z = (result == '0);

    always_comb begin
        acc_next = acc;
        if (op == OP_ACC) begin
            acc_next = result;
        end else if (op == OP_ACLR) begin
            acc_next = '0;
        end
    end
endmodule

// File: rtl/small_alu_pipe.sv
// Two-stage pipelined ALU with accumulator and valid/ready backpressure on both sides.
// S1 holds the operand beat; S2 holds the computed result and flags.
module small_alu_pipe
    import small_alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    small_alu_pipe_if.slave  bus
);
    logic             s1_valid;
    logic [OPW-1:0]   s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] core_acc_next;
    logic             core_c;
    logic             core_z;
    logic             core_v;
    logic             s1_adv;
    logic             s2_adv;

    assign s2_adv      = !bus.out_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // The core sees the live accumulator, so an ACC beat moving S1->S2 already
    // sees the update made by the ACC beat that moved on the previous edge.
    small_alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .acc      (acc),
        .result   (core_result),
        .acc_next (core_acc_next),
        .c        (core_c),
        .z        (core_z),
        .v        (core_v)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_op         <= '0;
            s1_a          <= '0;
            s1_b          <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flag_c    <= 1'b0;
            bus.flag_z    <= 1'b0;
            bus.flag_v    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op <= bus.op;
                    s1_a  <= bus.a;
                    s1_b  <= bus.b;
                end
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.result <= core_result;
                    bus.flag_c <= core_c;
                    bus.flag_z <= core_z;
                    bus.flag_v <= core_v;
                    acc        <= core_acc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_small_alu_pipe.sv
// Self-checking bench for small_alu_pipe: directed scenarios plus a random stream
// scored against an integer-arithmetic reference model.
module tb_small_alu_pipe;
    localparam int W    = 3;
    localparam int MOD  = 1 << W;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic clk = 1'b0;
    logic reset;

    small_alu_pipe_if #(.WIDTH(W)) bus ();

    small_alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         passed = 0;
    int         total  = 0;
    int         m_acc  = 0;
    logic [5:0] exp_q[$];

    function automatic int to_signed(input int x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    // Expected {result[2:0], c, z, v}; also advances the model accumulator.
    function automatic logic [5:0] model(input int op, input int a, input int b);
        int r;
        int s;
        int ss;
        bit c;
        bit v;
        r = 0; c = 0; v = 0; s = 0; ss = 0;
        case (op)
            0: begin
                s = a + b; r = s % MOD; c = (s >= MOD);
                ss = to_signed(a) + to_signed(b); v = (ss > SMAX) || (ss < SMIN);
            end
            1: begin
                s = a - b; r = (s + MOD) % MOD; c = (a < b);
                ss = to_signed(a) - to_signed(b); v = (ss > SMAX) || (ss < SMIN);
            end
            2: r = a ^ b;
            3: r = a & b;
            4: r = a | b;
            5: r = b;
            6: begin
                s = m_acc + a; r = s % MOD; c = (s >= MOD);
                ss = to_signed(m_acc) + to_signed(a); v = (ss > SMAX) || (ss < SMIN);
                m_acc = r;
            end
            default: begin
                r = 0; m_acc = 0;
            end
        endcase
        return {3'(r), c, (r == 0), v};
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
    endtask

    task automatic drive_beat(input int op, input int a, input int b);
        bus.in_valid = 1'b1;
        bus.op       = 3'(op);
        bus.a        = 3'(a);
        bus.b        = 3'(b);
    endtask

    // Sends one beat into an idle pipe with out_ready high and returns the
    // output beat plus the number of clock edges from acceptance to out_valid.
    task automatic send_one(input int op, input int a, input int b,
                            output logic [5:0] got, output int lat);
        int n;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_beat(op, a, b);
        #1;
        n = 0;
        while (!bus.in_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        drive_idle();
        #1;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        got = {bus.result, bus.flag_c, bus.flag_z, bus.flag_v};
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_acc = 0;
        exp_q.delete();
        @(negedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else passed++;
        total++;
        if (bus.result !== 3'd0) $display("FAIL reset_result got=%0d exp=0", bus.result);
        else passed++;
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {bus.flag_c, bus.flag_z, bus.flag_v});
        else passed++;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({bus.out_valid, bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== 7'd0)
            $display("FAIL idle_after_reset got=%b exp=0000000",
                     {bus.out_valid, bus.result, bus.flag_c, bus.flag_z, bus.flag_v});
        else passed++;
    endtask

    task automatic test_arith();
        int         ops[4] = '{0, 1, 1, 0};
        int         as[4]  = '{3, 2, 4, 3};
        int         bs[4]  = '{6, 5, 4, 1};
        logic [5:0] exps[4] = '{{3'd1, 3'b100}, {3'd5, 3'b101}, {3'd0, 3'b010}, {3'd4, 3'b001}};
        logic [5:0] got;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            send_one(ops[i], as[i], bs[i], got, lat);
            total++;
            if (lat !== 2) $display("FAIL arith_latency[%0d] got=%0d exp=2", i, lat);
            else passed++;
            total++;
            if (got !== exps[i])
                $display("FAIL arith[%0d] got r=%0d czv=%b exp r=%0d czv=%b",
                         i, got[5:3], got[2:0], exps[i][5:3], exps[i][2:0]);
            else passed++;
        end
    endtask

    task automatic test_acc();
        int ops[4]  = '{7, 6, 6, 6};
        int as[4]   = '{0, 2, 3, 5};
        int rexp[4] = '{0, 2, 5, 2};
        int cexp[4] = '{0, 0, 0, 1};
        int idx;
        int k;
        int first;
        int last;
        idx = 0; k = 0; first = -1; last = -1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (idx < 4) drive_beat(ops[idx], as[idx], 0);
            else drive_idle();
            #1;
            if (bus.out_valid && k < 4) begin
                total++;
                if (bus.result !== 3'(rexp[k]) || bus.flag_c !== 1'(cexp[k]))
                    $display("FAIL acc_seq[%0d] got r=%0d c=%b exp r=%0d c=%0d",
                             k, bus.result, bus.flag_c, rexp[k], cexp[k]);
                else passed++;
                if (first < 0) first = cyc;
                last = cyc;
                k++;
            end
            if (bus.in_valid && bus.in_ready) begin
                void'(model(ops[idx], as[idx], 0));
                idx++;
            end
        end
        total++;
        if (k !== 4 || (last - first) !== 3)
            $display("FAIL acc_throughput got beats=%0d span=%0d exp beats=4 span=3", k, last - first);
        else passed++;
    endtask

    task automatic test_stall();
        int         bop[6];
        int         ba[6];
        int         bb[6];
        int         sent;
        int         got_n;
        bit         prev_stall;
        logic [5:0] prev_val;
        logic [5:0] cur;
        logic [5:0] e;
        for (int i = 0; i < 6; i++) begin
            bop[i] = $urandom_range(0, 7);
            ba[i]  = $urandom_range(0, MOD - 1);
            bb[i]  = $urandom_range(0, MOD - 1);
        end
        sent = 0; got_n = 0; prev_stall = 0; prev_val = '0;
        for (int cyc = 0; cyc < 40 && got_n < 6; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 6) drive_beat(bop[sent], ba[sent], bb[sent]);
            else drive_idle();
            #1;
            cur = {bus.result, bus.flag_c, bus.flag_z, bus.flag_v};
            if (cyc >= 3 && cyc <= 6) begin
                total++;
                if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got=%b exp=0", cyc, bus.in_ready);
                else passed++;
            end
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || cur !== prev_val)
                    $display("FAIL stall_hold[%0d] got v=%b data=%b exp v=1 data=%b",
                             cyc, bus.out_valid, cur, prev_val);
                else passed++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_val   = cur;
            if (bus.out_valid && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
                total++;
                if (cur !== e)
                    $display("FAIL stall_beat[%0d] got r=%0d czv=%b exp r=%0d czv=%b",
                             got_n, cur[5:3], cur[2:0], e[5:3], e[2:0]);
                else passed++;
                got_n++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bop[sent], ba[sent], bb[sent]));
                sent++;
            end
        end
        total++;
        if (got_n !== 6 || exp_q.size() !== 0)
            $display("FAIL stall_count got=%0d left=%0d exp=6 left=0", got_n, exp_q.size());
        else passed++;
        drive_idle();
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        int         lat;
        send_one(7, 0, 0, got, lat);
        void'(model(7, 0, 0));
        send_one(6, 5, 0, got, lat);
        void'(model(6, 5, 0));
        total++;
        if (got[5:3] !== 3'd5) $display("FAIL premid_acc got=%0d exp=5", got[5:3]);
        else passed++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_beat(6, 3, 0);
        @(negedge clk);
        drive_beat(0, 1, 1);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_acc = 0;
        exp_q.delete();
        #1;
        total++;
        if ({bus.out_valid, bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== 7'd0 || bus.in_ready !== 1'b1)
            $display("FAIL midreset_state got v=%b r=%0d czv=%b rdy=%b exp v=0 r=0 czv=000 rdy=1",
                     bus.out_valid, bus.result, {bus.flag_c, bus.flag_z, bus.flag_v}, bus.in_ready);
        else passed++;
        send_one(6, 1, 0, got, lat);
        void'(model(6, 1, 0));
        total++;
        if (got !== {3'd1, 3'b000} || lat !== 2)
            $display("FAIL postreset_acc got r=%0d czv=%b lat=%0d exp r=1 czv=000 lat=2",
                     got[5:3], got[2:0], lat);
        else passed++;
    endtask

    task automatic test_random();
        logic [5:0] cur;
        logic [5:0] e;
        int         op;
        int         a;
        int         b;
        int         beats;
        beats = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                bus.out_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 3) != 0) begin
                    op = $urandom_range(0, 7);
                    a  = $urandom_range(0, MOD - 1);
                    b  = $urandom_range(0, MOD - 1);
                    drive_beat(op, a, b);
                end else begin
                    drive_idle();
                end
            end else begin
                bus.out_ready = 1'b1;
                drive_idle();
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                cur = {bus.result, bus.flag_c, bus.flag_z, bus.flag_v};
                e   = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
                total++;
                if (cur !== e)
                    $display("FAIL random_beat[%0d] got r=%0d czv=%b exp r=%0d czv=%b",
                             beats, cur[5:3], cur[2:0], e[5:3], e[2:0]);
                else passed++;
                beats++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(int'(bus.op), int'(bus.a), int'(bus.b)));
        end
        total++;
        if (exp_q.size() !== 0 || beats < 100)
            $display("FAIL random_drain got left=%0d beats=%0d exp left=0 beats>=100", exp_q.size(), beats);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_acc();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/small_alu_pipe.md
Name: small_alu_pipe

Overview:
Parametrised, pipelined successor of the team's 3-bit registered small ALU. Widens operands to WIDTH bits and extends the op set with OR, PASS and an internal accumulator. Adds carry/zero/overflow flags and a valid/ready handshake on both sides so it can sit in streaming datapaths with backpressure. Fixed 2-cycle latency when not stalled.

Parameters:
WIDTH, 3, operand/result/accumulator width in bits (>=2)
OPW, 3, opcode width (fixed at 3; exposed for package consistency)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
op  input  OPW  opcode (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
result  output  WIDTH  result
flag_c  output  1  carry (ADD/ACC) / borrow (SUB); 0 for other ops
flag_z  output  1  result == 0
flag_v  output  1  signed overflow (ADD/SUB/ACC); 0 for other ops

Behaviour:
- One clock domain; reset is synchronous and active-high (ports clk, reset).
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 XOR; 3 AND; 4 OR; 5 PASS b; 6 ACC acc_next=acc+a, result=acc_next; 7 ACLR acc_next=0, result=0.
- Arithmetic computed at WIDTH+1 bits; result = low WIDTH bits (wrap-around); flag_c = bit WIDTH (SUB: 1 when a<b unsigned).
- flag_v: ADD/ACC: operands same sign, result sign differs; SUB: a,b signs differ, result sign differs from a.
- Pipeline: S1 registers {op,a,b}; S2 computes and registers {result,flags}. Beat accepted at cycle N (in_valid & in_ready) appears with out_valid at N+2 when unstalled.
- s2_adv = !out_valid | out_ready; S2 loads from S1 when s2_adv (out_valid <= s1_valid).
- s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no dependency on in_valid).
- Full throughput: one beat/cycle with out_ready held high.
- Stall: out_valid & !out_ready holds result/flags stable; S1 holds; in_ready drops once S1 is full.
- Accumulator: WIDTH-bit register, updated only when an ACC/ACLR beat moves S1->S2; never on stalled cycles. Back-to-back ACC beats see each other's updates (forward acc_next within S2 compute).
- Simultaneous S1 load and S2 load in the same cycle is normal operation; no bubble inserted.
- Reset: s1_valid=0, out_valid=0, result=0, flags=0, acc=0, in_ready=1 the cycle after reset deasserts. Reset mid-operation discards all in-flight beats; no partial output.
- Data/flags are don't-care for consumers while out_valid=0 but must stay 0 after reset until the first beat.

Decomposition:
- Package small_alu_pkg: opcode localparams (OP_ADD..OP_ACLR), OPW, a function computing {c,v,result} for a given op.
- Sub-module small_alu_core: purely combinational op/flag evaluation (op,a,b,acc -> result,c,z,v,acc_next), instanced in S2; the top holds pipeline regs, handshake and accumulator.

Test Plan:
- WIDTH=3, ADD a=3 b=6, out_ready=1 -> two cycles later result=1, c=1, z=0, v=0 (3+(-2)=1 signed).
- SUB a=2 b=5 -> result=5, c=1; SUB a=4 b=4 -> result=0, z=1, c=0; ADD a=3 b=1 -> result=4, v=1.
- ACLR then ACC a=2, a=3, a=5 back-to-back -> results 0,2,5,2 (wrap, c=1 on last), one per cycle.
- Burst of 6 beats with out_ready low for cycles 3-6 -> in_ready low after 2 beats held; results hold stable; all 6 emerge in order, none lost or duplicated.
- Assert reset while 2 beats in flight and acc=5 -> next cycle out_valid=0, result=0, flags=0; subsequent ACC a=1 -> result=1.
- Random op/operand stream with random out_ready vs. reference model -> all results and flags match; XOR/AND/OR/PASS report c=0, v=0.
